// File: rtl/motor_ramp_limiter_pkg.sv
// Shared types, defaults and sizing helpers for the motor ramp limiter.
// Channel state encoding lives here so every file agrees on it.
package motor_ramp_limiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_DEAD  = 2'd3
  } ch_state_t;

  localparam int DEF_NCH = 6;
  localparam int DEF_DUTY_W = 16;
  localparam int DEF_TICK_DIV   = 1000;
  localparam int DEF_DEAD_TICKS = 50;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    if (max_val < 1) begin
      w = 1;
    end else begin
      w = $clog2(max_val + 1);
    end
    return w;
  endfunction

  function automatic logic state_drives(input ch_state_t s);
    return (s == ST_RUN) || (s == ST_BRAKE);
  endfunction

  function automatic logic state_busy(input ch_state_t s);
    return (s == ST_BRAKE) || (s == ST_DEAD);
  endfunction

endpackage

// File: rtl/motor_ramp_limiter_ramp_channel.sv
// One motor channel: run/brake/dead-time FSM with saturating duty ramp.
// All state moves only on the shared tick; every output is a register.
module ramp_channel
  import motor_ramp_limiter_pkg::*;
#(
  parameter int DUTY_W     = DEF_DUTY_W,
  parameter int DEAD_TICKS = DEF_DEAD_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              cmd_on,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic [DUTY_W-1:0] step,
  output logic              out_on,
  output logic              out_dir,
  output logic [DUTY_W-1:0] out_duty,
  output logic              busy
);

  localparam int CW = cnt_width(DEAD_TICKS);
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_TICKS);

  ch_state_t         state_r;
  ch_state_t         state_s;
  logic [CW-1:0]     dead_r;
  logic [CW-1:0]     dead_s;
  logic [CW-1:0]     dead_dec_s;
  logic              on_s;
  logic              dir_s;
  logic              busy_s;
  logic [DUTY_W-1:0] duty_s;
  logic [DUTY_W-1:0] target_s;
  logic [DUTY_W-1:0] toward_tgt_s;
  logic [DUTY_W-1:0] toward_zero_s;
  logic [DUTY_W-1:0] launch_s;

  // Move cur toward tgt by at most stp, in one extra bit so it can never wrap.
  function automatic logic [DUTY_W-1:0] ramp_to(input logic [DUTY_W-1:0] cur,
                                                input logic [DUTY_W-1:0] tgt,
                                                input logic [DUTY_W-1:0] stp);
    logic [DUTY_W:0] c;
    logic [DUTY_W:0] t;
    logic [DUTY_W:0] s;
    logic [DUTY_W:0] d;
    logic [DUTY_W:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = {1'b0, stp};
    d = '0;
    if (stp == '0) begin
      r = t;
    end else if (t > c) begin
      d = t - c;
      r = (s >= d) ? t : (c + s);
    end else begin
      d = c - t;
      r = (s >= d) ? t : (c - s);
    end
    return r[DUTY_W-1:0];
  endfunction

  assign target_s      = cmd_on ? cmd_duty : '0;
  assign toward_tgt_s  = ramp_to(out_duty, target_s, step);
  assign toward_zero_s = ramp_to(out_duty, '0, step);
  assign launch_s      = ramp_to('0, target_s, step);
  assign dead_dec_s    = (dead_r == '0) ? '0 : (dead_r - CW'(1));

  // Next-state and next-output decode, evaluated only on tick cycles.
  always_comb begin
    state_s = state_r;
    dead_s  = dead_r;
    dir_s   = out_dir;
    duty_s  = out_duty;
    if (tick) begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_on) begin
            state_s = ST_RUN;
            dir_s   = cmd_dir;
            duty_s  = launch_s;
          end else begin
            duty_s  = '0;
          end
        end
        ST_RUN, ST_BRAKE: begin
          // A reversal must bleed duty to zero before the direction may flip.
          if (cmd_dir != out_dir) begin
            if (toward_zero_s == '0) begin
              state_s = ST_DEAD;
              dead_s  = DEAD_LOAD;
              duty_s  = '0;
            end else begin
              state_s = ST_BRAKE;
              duty_s  = toward_zero_s;
            end
          end else begin
            duty_s = toward_tgt_s;
            if (!cmd_on && (toward_tgt_s == '0)) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RUN;
            end
          end
        end
        ST_DEAD: begin
          // Loading 0 or 1 both give a single dead tick.
          if (dead_dec_s == '0) begin
            dead_s = '0;
            if (cmd_on) begin
              state_s = ST_RUN;
              dir_s   = cmd_dir;
              duty_s  = launch_s;
            end else begin
              state_s = ST_IDLE;
              duty_s  = '0;
            end
          end else begin
            dead_s = dead_dec_s;
            duty_s = '0;
          end
        end
        default: begin
          state_s = ST_IDLE;
          dead_s  = '0;
          duty_s  = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    on_s   = state_drives(state_s);
    busy_s = state_busy(state_s);
  end

  // Channel state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      dead_r   <= '0;
      out_on   <= 1'b0;
      out_dir  <= 1'b0;
      out_duty <= '0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_s;
      dead_r   <= dead_s;
      out_on   <= on_s;
      out_dir  <= dir_s;
      out_duty <= duty_s;
      busy     <= busy_s;
    end
  end

endmodule

// File: rtl/motor_ramp_limiter.sv
// Multi-channel motor command ramp limiter: shared tick prescaler feeding
// NCH independent ramp_channel instances.
module motor_ramp_limiter
  import motor_ramp_limiter_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int DUTY_W     = DEF_DUTY_W,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEAD_TICKS = DEF_DEAD_TICKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*NCH-1:0]      cmd_in,
  input  logic [NCH*DUTY_W-1:0] cmd_duty,
  input  logic [DUTY_W-1:0]     step,
  output logic [2*NCH-1:0]      out_in,
  output logic [NCH*DUTY_W-1:0] out_duty,
  output logic [NCH-1:0]        busy
);

  localparam int PW = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_r;
  logic          tick_s;

  assign tick_s = (pre_r == PRE_LAST);

  // Free-running prescaler; restarts from zero on reset so the first tick lands TICK_DIV cycles out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_r <= '0;
    end else if (tick_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ramp_channel #(
      .DUTY_W     (DUTY_W),
      .DEAD_TICKS (DEAD_TICKS)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick_s),
      .cmd_on   (cmd_in[2*i+1]),
      .cmd_dir  (cmd_in[2*i]),
      .cmd_duty (cmd_duty[i*DUTY_W +: DUTY_W]),
      .step     (step),
      .out_on   (out_in[2*i+1]),
      .out_dir  (out_in[2*i]),
      .out_duty (out_duty[i*DUTY_W +: DUTY_W]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_motor_ramp_limiter.sv
// Self-checking bench for motor_ramp_limiter: directed table for the ramp and
// reversal, hand sequences for corner cases, then randomized model compare.
module tb_motor_ramp_limiter;

  localparam int NCH = 6;
  localparam int DW  = 16;
  localparam int TD  = 4;
  localparam int DT  = 3;

  localparam int M_OFF = 0, M_DRIVE = 1, M_STOP = 2, M_GAP = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [2*NCH-1:0]    cmd_in = '0;
  logic [NCH*DW-1:0]   cmd_duty = '0;
  logic [DW-1:0]       step = 16'd10;
  logic [2*NCH-1:0]    out_in;
  logic [NCH*DW-1:0]   out_duty;
  logic [NCH-1:0]      busy;

  int checks = 0;
  int failures = 0;
  int edges = 0;

  int m_mode [NCH];
  int m_dir  [NCH];
  int m_duty [NCH];
  int m_gap  [NCH];

  typedef struct {
    logic on;
    logic dir;
    int   duty;
    int   exp_duty;
    logic exp_on;
    logic exp_dir;
    logic exp_busy;
  } vec_t;

  vec_t tbl [12];

  motor_ramp_limiter #(
    .NCH(NCH), .DUTY_W(DW), .TICK_DIV(TD), .DEAD_TICKS(DT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_duty(cmd_duty),
    .step(step), .out_in(out_in), .out_duty(out_duty), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int approach(input int cur, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (tgt > cur) return (tgt - cur <= stp) ? tgt : cur + stp;
    return (cur - tgt <= stp) ? tgt : cur - stp;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = M_OFF; m_dir[i] = 0; m_duty[i] = 0; m_gap[i] = 0;
    end
  endtask

  // Behavioural channel rules applied once per tick to every channel.
  task automatic model_tick();
    for (int i = 0; i < NCH; i++) begin
      int on_c, dir_c, tgt, nd;
      on_c  = int'(cmd_in[2*i+1]);
      dir_c = int'(cmd_in[2*i]);
      tgt   = on_c != 0 ? int'(cmd_duty[i*DW +: DW]) : 0;
      case (m_mode[i])
        M_OFF: begin
          if (on_c != 0) begin
            m_mode[i] = M_DRIVE; m_dir[i] = dir_c; m_duty[i] = approach(0, tgt, int'(step));
          end
        end
        M_DRIVE, M_STOP: begin
          if (dir_c != m_dir[i]) begin
            nd = approach(m_duty[i], 0, int'(step));
            m_duty[i] = nd;
            if (nd == 0) begin
              m_mode[i] = M_GAP; m_gap[i] = (DT < 1) ? 1 : DT;
            end else begin
              m_mode[i] = M_STOP;
            end
          end else begin
            nd = approach(m_duty[i], tgt, int'(step));
            m_duty[i] = nd;
            m_mode[i] = (on_c == 0 && nd == 0) ? M_OFF : M_DRIVE;
          end
        end
        default: begin
          m_gap[i]--;
          if (m_gap[i] == 0) begin
            if (on_c != 0) begin
              m_mode[i] = M_DRIVE; m_dir[i] = dir_c; m_duty[i] = approach(0, tgt, int'(step));
            end else begin
              m_mode[i] = M_OFF;
            end
          end
        end
      endcase
    end
  endtask

  task automatic model_check(input string nm);
    logic [2*NCH-1:0]  e_in;
    logic [NCH*DW-1:0] e_duty;
    logic [NCH-1:0]    e_busy;
    for (int i = 0; i < NCH; i++) begin
      e_in[2*i+1]        = (m_mode[i] == M_DRIVE) || (m_mode[i] == M_STOP);
      e_in[2*i]          = (m_dir[i] != 0);
      e_duty[i*DW +: DW] = DW'(m_duty[i]);
      e_busy[i]          = (m_mode[i] == M_STOP) || (m_mode[i] == M_GAP);
    end
    chk({nm, "_out_in"}, 128'(out_in), 128'(e_in));
    chk({nm, "_out_duty"}, 128'(out_duty), 128'(e_duty));
    chk({nm, "_busy"}, 128'(busy), 128'(e_busy));
  endtask

  task automatic set_ch(input int i, input logic on, input logic dir, input int duty);
    cmd_in[2*i+1] = on;
    cmd_in[2*i]   = dir;
    cmd_duty[i*DW +: DW] = DW'(duty);
  endtask

  function automatic int duty_of(input int i);
    return int'(out_duty[i*DW +: DW]);
  endfunction

  task automatic cyc(output bit was_tick);
    @(posedge clk);
    edges++;
    was_tick = (edges % TD == 0);
    if (was_tick) model_tick();
    #1;
  endtask

  task automatic run_tick();
    bit t;
    t = 1'b0;
    for (int k = 0; k < TD && !t; k++) cyc(t);
    if (!t) begin
      checks++; failures++;
      $display("FAIL tick_budget actual=no_tick expected=tick");
    end
  endtask

  initial begin
    bit t;
    int off_cnt;
    bit seen_on;

    tbl[0]  = '{1'b1, 1'b0, 35, 10, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 35, 20, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 35, 30, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 35, 35, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 35, 25, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 35, 15, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 35,  5, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 35,  0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 35,  0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 35,  0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 35, 10, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 35, 20, 1'b1, 1'b1, 1'b0};

    model_reset();
    #1;
    model_check("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    edges = 0;

    // Ramp up then reverse on channel 0.
    for (int v = 0; v < 12; v++) begin
      set_ch(0, tbl[v].on, tbl[v].dir, tbl[v].duty);
      run_tick();
      chk($sformatf("tbl%0d_duty", v), 128'(duty_of(0)), 128'(tbl[v].exp_duty));
      chk($sformatf("tbl%0d_on", v), 128'(out_in[1]), 128'(tbl[v].exp_on));
      chk($sformatf("tbl%0d_dir", v), 128'(out_in[0]), 128'(tbl[v].exp_dir));
      chk($sformatf("tbl%0d_busy", v), 128'(busy[0]), 128'(tbl[v].exp_busy));
      model_check("tbl_model");
    end

    // Abort a brake on channel 1; its direction must never change.
    set_ch(1, 1'b1, 1'b0, 50);
    repeat (5) run_tick();
    chk("abort_start", 128'(duty_of(1)), 128'd50);
    set_ch(1, 1'b1, 1'b1, 50);
    repeat (2) begin
      run_tick();
      chk("abort_dir_hold", 128'(out_in[2]), 128'd0);
      chk("abort_busy", 128'(busy[1]), 128'd1);
    end
    chk("abort_mid", 128'(duty_of(1)), 128'd30);
    set_ch(1, 1'b1, 1'b0, 50);
    run_tick();
    chk("abort_busy_fall", 128'(busy[1]), 128'd0);
    chk("abort_back1", 128'(duty_of(1)), 128'd40);
    run_tick();
    chk("abort_back2", 128'(duty_of(1)), 128'd50);
    chk("abort_dir_end", 128'(out_in[2]), 128'd0);
    model_check("abort");

    // Channel 2 switches off while channel 3 ramps up.
    set_ch(2, 1'b1, 1'b0, 25);
    repeat (3) run_tick();
    chk("off_start", 128'(duty_of(2)), 128'd25);
    set_ch(2, 1'b0, 1'b0, 25);
    set_ch(3, 1'b1, 1'b1, 100);
    run_tick();
    chk("off_d1", 128'(duty_of(2)), 128'd15);
    run_tick();
    chk("off_d2", 128'(duty_of(2)), 128'd5);
    run_tick();
    chk("off_d3", 128'(duty_of(2)), 128'd0);
    chk("off_on", 128'(out_in[5]), 128'd0);
    chk("off_busy", 128'(busy[2]), 128'd0);
    chk("conc_ch3", 128'(duty_of(3)), 128'd30);
    chk("conc_ch3_on", 128'(out_in[7]), 128'd1);
    model_check("off");

    // Bypass ramping with step=0, then reverse: dead time still applies.
    step = 16'd0;
    set_ch(4, 1'b1, 1'b0, 1000);
    run_tick();
    chk("bypass_jump", 128'(duty_of(4)), 128'd1000);
    set_ch(4, 1'b1, 1'b1, 1000);
    off_cnt = 0;
    seen_on = 1'b0;
    for (int k = 0; k < 8 && !seen_on; k++) begin
      run_tick();
      if (out_in[9]) seen_on = 1'b1;
      else off_cnt++;
    end
    chk("bypass_dead_len", 128'(off_cnt), 128'(DT));
    chk("bypass_resume", 128'(duty_of(4)), 128'd1000);
    chk("bypass_newdir", 128'(out_in[8]), 128'd1);
    model_check("bypass");

    // Drive channel 0 into dead time, then reset in the middle of it.
    step = 16'd10;
    set_ch(0, 1'b1, 1'b0, 35);
    repeat (4) run_tick();
    chk("rst_in_dead", 128'(busy[0]), 128'd1);
    chk("rst_dead_off", 128'(out_in[1]), 128'd0);
    cyc(t);
    reset = 1'b0;
    #1;
    model_reset();
    model_check("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    edges = 0;
    for (int k = 1; k < TD; k++) begin
      cyc(t);
      chk($sformatf("rst_quiet%0d", k), 128'(out_duty), 128'd0);
    end
    cyc(t);
    chk("rst_first_tick", 128'(duty_of(0)), 128'd10);
    model_check("rst_after");

    // Randomized commands against the model.
    for (int r = 0; r < 160; r++) begin
      if (r % 20 == 0) step = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 9) == 0) cmd_in[2*i+1] = ~cmd_in[2*i+1];
        if ($urandom_range(0, 11) == 0) cmd_in[2*i] = ~cmd_in[2*i];
        if ($urandom_range(0, 4) == 0)
          cmd_duty[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(60000, 65535))
                                                              : 16'($urandom_range(0, 3000));
      end
      run_tick();
      model_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_ramp_limiter.md
MOTOR_RAMP_LIMITER -- requirements
Module: motor_ramp_limiter

Interface
REQ-001 Parameter NCH, default 6, number of motor channels.
REQ-002 Parameter DUTY_W, default 16, duty-cycle width per channel.
REQ-003 Parameter TICK_DIV, default 1000, clk cycles per ramp tick.
REQ-004 Parameter DEAD_TICKS, default 50, ticks of forced-off dead interval on direction reversal.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 cmd_in  in  2*NCH  commanded {on, dir} per channel; channel i: bit 2i+1 = on, bit 2i = dir.
REQ-009 cmd_duty  in  NCH*DUTY_W  commanded duty; channel i occupies slice i.
REQ-010 step  in  DUTY_W  duty change per tick; 0 = bypass ramping.
REQ-011 out_in  out  2*NCH  ramped {on, dir} to PWM stage, same packing as cmd_in.
REQ-012 out_duty  out  NCH*DUTY_W  ramped duty to PWM stage.
REQ-013 busy  out  NCH  channel i in BRAKE or DEAD.

Function
REQ-014 Shared prescaler counts 0..TICK_DIV-1; tick asserts one cycle when count = TICK_DIV-1, then wraps to 0.
REQ-015 Per channel target T = on ? cmd_duty : 0; all state changes happen only on tick cycles; outputs registered, updating the cycle after the tick.
REQ-016 Ramp: duty moves toward T by min(step, |T-duty|); compare and add in DUTY_W+1 bits, never overshooting or wrapping; step=0 sets duty = T on the tick.
REQ-017 States per channel: IDLE, RUN, BRAKE, DEAD.
REQ-018 IDLE: out on=0, duty=0; on tick with cmd on=1, latch out dir=cmd dir and enter RUN.
REQ-019 RUN: out on=1; ramp toward T; if cmd dir != out dir and duty != 0 -> BRAKE; if cmd dir != out dir and duty = 0 -> DEAD; if cmd on=0 and duty reaches 0 -> IDLE.
REQ-020 BRAKE: out on=1, dir unchanged, ramp toward 0 with step; cmd dir returns equal to out dir -> RUN (abort brake); duty reaches 0 -> DEAD, load dead counter = DEAD_TICKS.
REQ-021 DEAD: out on=0, duty=0; counter decrements per tick; at 0: cmd on=1 -> latch dir, RUN; cmd on=0 -> IDLE; command changes during DEAD are not acted on before expiry.
REQ-022 DEAD_TICKS = 0: DEAD lasts exactly one tick.
REQ-023 out dir never changes while out on=1 and duty != 0.
REQ-024 Channels fully independent; simultaneous events on several channels in one tick are all processed that tick.
REQ-025 busy = 1 in BRAKE or DEAD, else 0.

Reset
REQ-026 On reset low: all channels IDLE, out_in=0, out_duty=0, busy=0, prescaler=0, dead counters=0, asynchronously.
REQ-027 Reset asserted mid-ramp or mid-DEAD forces the REQ-026 state immediately; after release the first tick occurs TICK_DIV cycles later.

Structure
REQ-028 State encoding, NCH and DUTY_W defaults live in shared defines.v; DUTY_W default equals `PERIOD_LENGTH where defined.
REQ-029 One sub-module, ramp_channel (FSM, ramp arithmetic, dead counter), instantiated NCH times by generate; prescaler in top level.

Verification (bench: TICK_DIV=4, DEAD_TICKS=3, step=10)
REQ-030 Ramp up: ch0 cmd on=1, dir=0, duty 0->35 -> out_duty 10,20,30,35 on successive ticks, out on=1 throughout.
REQ-031 Reversal: ch0 at 35 dir=0, cmd dir=1 -> 25,15,5,0 (busy=1), 3 ticks on=0, then dir=1, on=1, ramp toward 35.
REQ-032 Abort brake: ch1 at 50, flip dir, after 2 ticks (duty 30) restore dir -> RUN, duty ramps back to 50, busy falls, out dir never changes.
REQ-033 Bypass: step=0, cmd duty 0->1000 -> out_duty=1000 on first tick; reversal still yields 3-tick DEAD.
REQ-034 Off: ch2 at 25, cmd on=0 -> 15,5,0 then IDLE, on=0; channel 3 ramping concurrently is unaffected.
REQ-035 Reset mid-DEAD: reset low 2 cycles -> all outputs 0 immediately; first update TICK_DIV cycles after release.
